// File: rtl/mem_req_arbiter.sv
// Load/store request arbiter for the single-port data memory: two FIFOs, round-robin grant, hold-until-ack handshake.
// Optional macro MEM_ARB_RAW_HAZARD_EN holds a load back while a queued store targets the same word.
module mem_req_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          cpu_clk_aon,
  input  logic          i_rst,
  input  logic          rd_req,
  input  logic [4:0]    rd_req_reg,
  input  logic [2:0]    rd_req_func3,
  input  logic [AW-1:0] rd_req_addr,
  output logic          rd_full,
  input  logic          wr_req,
  input  logic [4:0]    wr_req_reg,
  input  logic [AW-1:0] wr_req_addr,
  input  logic [DW-1:0] wr_req_data,
  output logic          wr_full,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          rd_valid,
  output logic [4:0]    rd_valid_reg,
  output logic [2:0]    rd_valid_func3,
  output logic [DW-1:0] rd_data,
  output logic          wr_done,
  output logic [4:0]    wr_done_reg,
  output logic          overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = 5 + 3 + AW;
  localparam int WW = 5 + AW + DW;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2} state_t;

  state_t          state_r, state_nx_s;
  logic [RW-1:0]   rd_mem_r [DEPTH];
  logic [WW-1:0]   wr_mem_r [DEPTH];
  logic [PW-1:0]   rd_wptr_r, rd_rptr_r, wr_wptr_r, wr_rptr_r;
  logic [CW-1:0]   rd_cnt_r, wr_cnt_r, rd_cnt_nx_s, wr_cnt_nx_s;
  logic            rd_full_r, wr_full_r, last_wr_r, ovf_r;
  logic            rd_push_s, wr_push_s, rd_pop_s, wr_pop_s;
  logic            rd_elig_s, wr_elig_s, rd_hazard_s, grant_rd_s, grant_wr_s;
  logic [RW-1:0]   rd_head_s;
  logic [WW-1:0]   wr_head_s;
  logic            mem_req_r, mem_we_r, rd_valid_r, wr_done_r;
  logic [AW-1:0]   mem_addr_r;
  logic [DW-1:0]   mem_wdata_r, rd_data_r;
  logic [4:0]      rd_valid_reg_r, wr_done_reg_r;
  logic [2:0]      rd_valid_func3_r;

  assign rd_head_s = rd_mem_r[rd_rptr_r];
  assign wr_head_s = wr_mem_r[wr_rptr_r];
  assign rd_pop_s  = (state_r == RD_WAIT) && mem_ack;
  assign wr_pop_s  = (state_r == WR_WAIT) && mem_ack;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign rd_push_s = rd_req && (!rd_full_r || rd_pop_s);
  assign wr_push_s = wr_req && (!wr_full_r || wr_pop_s);
  assign rd_elig_s = (rd_cnt_r != CW'(0)) && !rd_hazard_s;
  assign wr_elig_s = (wr_cnt_r != CW'(0));

`ifdef MEM_ARB_RAW_HAZARD_EN
  // Word-address match of the load head against every occupied store slot.
  always_comb begin
    rd_hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_hazard_s = rd_hazard_s |
        (({1'b0, PW'(i) - wr_rptr_r} < wr_cnt_r) &&
         (wr_mem_r[i][DW+AW-1:DW+2] == rd_head_s[AW-1:2]));
    end
  end
`else
  assign rd_hazard_s = 1'b0;
`endif

  // Occupancy after this cycle's push/pop.
  always_comb begin
    rd_cnt_nx_s = rd_cnt_r + CW'(rd_push_s) - CW'(rd_pop_s);
    wr_cnt_nx_s = wr_cnt_r + CW'(wr_push_s) - CW'(wr_pop_s);
  end

  // FIFO storage (no reset needed, validity tracked by the counters).
  always_ff @(posedge cpu_clk_aon) begin
    if (rd_push_s) rd_mem_r[rd_wptr_r] <= {rd_req_reg, rd_req_func3, rd_req_addr};
    if (wr_push_s) wr_mem_r[wr_wptr_r] <= {wr_req_reg, wr_req_addr, wr_req_data};
  end

  // FIFO pointers, counts and registered full flags.
  always_ff @(posedge cpu_clk_aon or posedge i_rst) begin
    if (i_rst) begin
      rd_wptr_r <= PW'(0);
      rd_rptr_r <= PW'(0);
      wr_wptr_r <= PW'(0);
      wr_rptr_r <= PW'(0);
      rd_cnt_r  <= CW'(0);
      wr_cnt_r  <= CW'(0);
      rd_full_r <= 1'b0;
      wr_full_r <= 1'b0;
    end else begin
      if (rd_push_s) rd_wptr_r <= rd_wptr_r + PW'(1);
      if (rd_pop_s)  rd_rptr_r <= rd_rptr_r + PW'(1);
      if (wr_push_s) wr_wptr_r <= wr_wptr_r + PW'(1);
      if (wr_pop_s)  wr_rptr_r <= wr_rptr_r + PW'(1);
      rd_cnt_r  <= rd_cnt_nx_s;
      wr_cnt_r  <= wr_cnt_nx_s;
      rd_full_r <= (rd_cnt_nx_s == FULL_CNT);
      wr_full_r <= (wr_cnt_nx_s == FULL_CNT);
    end
  end

  // FSM state register.
  always_ff @(posedge cpu_clk_aon or posedge i_rst) begin
    if (i_rst) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // Next state and round-robin grant; last_wr_r favours the other side on contention.
  always_comb begin
    state_nx_s = state_r;
    grant_rd_s = 1'b0;
    grant_wr_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (rd_elig_s && (!wr_elig_s || last_wr_r)) begin
          grant_rd_s = 1'b1;
          state_nx_s = RD_WAIT;
        end else if (wr_elig_s) begin
          grant_wr_s = 1'b1;
          state_nx_s = WR_WAIT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (mem_ack) state_nx_s = IDLE;
        else         state_nx_s = RD_WAIT;
      end
      WR_WAIT: begin
        if (mem_ack) state_nx_s = IDLE;
        else         state_nx_s = WR_WAIT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Registered memory-side and completion outputs.
  always_ff @(posedge cpu_clk_aon or posedge i_rst) begin
    if (i_rst) begin
      mem_req_r        <= 1'b0;
      mem_we_r         <= 1'b0;
      mem_addr_r       <= {AW{1'b0}};
      mem_wdata_r      <= {DW{1'b0}};
      rd_valid_r       <= 1'b0;
      rd_valid_reg_r   <= 5'd0;
      rd_valid_func3_r <= 3'd0;
      rd_data_r        <= {DW{1'b0}};
      wr_done_r        <= 1'b0;
      wr_done_reg_r    <= 5'd0;
      last_wr_r        <= 1'b1;
      ovf_r            <= 1'b0;
    end else begin
      mem_req_r <= (state_nx_s != IDLE);
      mem_we_r  <= (state_nx_s == WR_WAIT);
      if (grant_rd_s) begin
        mem_addr_r <= rd_head_s[AW-1:0];
        last_wr_r  <= 1'b0;
      end else if (grant_wr_s) begin
        mem_addr_r  <= wr_head_s[DW+AW-1:DW];
        mem_wdata_r <= wr_head_s[DW-1:0];
        last_wr_r   <= 1'b1;
      end
      rd_valid_r <= rd_pop_s;
      if (rd_pop_s) begin
        rd_valid_reg_r   <= rd_head_s[AW+7:AW+3];
        rd_valid_func3_r <= rd_head_s[AW+2:AW];
        rd_data_r        <= mem_rdata;
      end
      wr_done_r <= wr_pop_s;
      if (wr_pop_s) wr_done_reg_r <= wr_head_s[WW-1:DW+AW];
      ovf_r <= ovf_r | (rd_req && !rd_push_s) | (wr_req && !wr_push_s);
    end
  end

  assign rd_full        = rd_full_r;
  assign wr_full        = wr_full_r;
  assign mem_req        = mem_req_r;
  assign mem_we         = mem_we_r;
  assign mem_addr       = mem_addr_r;
  assign mem_wdata      = mem_wdata_r;
  assign rd_valid       = rd_valid_r;
  assign rd_valid_reg   = rd_valid_reg_r;
  assign rd_valid_func3 = rd_valid_func3_r;
  assign rd_data        = rd_data_r;
  assign wr_done        = wr_done_r;
  assign wr_done_reg    = wr_done_reg_r;
  assign overflow_err   = ovf_r;

endmodule
